// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and keeps at most one instruction-memory request outstanding.
// It fills the IF/ID register and absorbs hazard stalls and EX redirects.
module if_fetch_stage #(
  parameter int                   PC_W      = 9,
  parameter int                   INSTR_W   = 32,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               ifid_valid_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [1:0]         dbg_state
);

  // Handshake: imem_req is a single-cycle offer that memory always accepts in the
  // cycle it is high; imem_rvalid answers the one outstanding request, one or more
  // cycles later, and is consumed in the cycle it is high.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               hold_valid_q, hold_valid_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               resp_live;

  // A response only counts when it belongs to a request we still care about.
  assign resp_live = (state_q == ST_WAIT) && imem_rvalid;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    imem_req     = 1'b0;

    if (redirect_i) begin
      pc_d         = redirect_pc_i & ALIGN_MASK;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      hold_valid_d = 1'b0;
      if (state_q == ST_WAIT) begin
        state_d = imem_rvalid ? ST_IDLE : ST_DROP;
      end
    end else begin
      if ((state_q == ST_DROP) && imem_rvalid) begin
        state_d = ST_IDLE;
      end

      if (!stall_i) begin
        if (hold_valid_q) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = hold_pc_q;
          ifid_instr_d = hold_instr_q;
          hold_valid_d = 1'b0;
        end else if (resp_live) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = req_pc_q;
          ifid_instr_d = imem_rdata;
        end else begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end

      // Park the response when IF/ID cannot take it this cycle.
      if (resp_live && (stall_i || hold_valid_q)) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = req_pc_q;
        hold_instr_d = imem_rdata;
      end

      if (resp_live) begin
        state_d = ST_IDLE;
      end

      // A full hold buffer at end of cycle blocks new fetches until it drains.
      imem_req = rst_n && !hold_valid_d && ((state_q == ST_IDLE) || resp_live);

      if (imem_req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_STEP;
        state_d  = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory model plus a program-order stream model
// that predicts every IF/ID entry from redirects alone.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        ifid_valid_o;
  logic [8:0]  ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic [1:0]  dbg_state;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_instr_o  (ifid_instr_o),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time expired before the summary");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_entries = 0;

  bit         mem_pend;
  logic [8:0] mem_addr_q;
  int         mem_cnt;
  int         lat_min = 1;
  int         lat_max = 1;

  logic [8:0] exp_q[$];     // program-order PCs still to be seen in IF/ID
  logic       last_req;
  logic [8:0] last_addr;

  function automatic logic [31:0] instr_of(logic [8:0] a);
    return {8'hA5, 7'h00, a, 8'h3C};
  endfunction

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    rst_n       = 1'b0;
    mem_pend    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(9'd0);
  endtask

  // One pipeline cycle: present memory response, sample combinational request,
  // clock, then update the memory model and the stream model.
  task automatic cycle();
    logic        req_s, rv_s, stall_s, redir_s;
    logic [8:0]  addr_s, rpc_s, pc_prev, nxt;
    logic        v_prev;
    logic [31:0] in_prev;
    imem_rvalid = mem_pend && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? instr_of(mem_addr_q) : $urandom();
    #1;
    req_s   = imem_req;
    addr_s  = imem_addr;
    rv_s    = imem_rvalid;
    stall_s = stall;
    redir_s = redirect;
    rpc_s   = redirect_pc;
    v_prev  = ifid_valid_o;
    pc_prev = ifid_pc_o;
    in_prev = ifid_instr_o;
    if (req_s) begin
      check_eq("addr_align", addr_s[1:0], 0);
      check_eq("one_outstanding", mem_pend && !rv_s, 0);
    end
    last_req  = req_s;
    last_addr = addr_s;
    @(posedge clk);
    #1;
    if (rv_s) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (req_s) begin
      mem_pend   = 1'b1;
      mem_addr_q = addr_s;
      mem_cnt    = $urandom_range(lat_max, lat_min) - 1;
    end
    if (redir_s) begin
      check_eq("redir_bubble", {ifid_valid_o, ifid_pc_o, ifid_instr_o}, {1'b0, pc_prev, NOP});
      exp_q.delete();
      exp_q.push_back(rpc_s & 9'h1FC);
    end else if (stall_s) begin
      check_eq("stall_keep", {ifid_valid_o, ifid_pc_o, ifid_instr_o}, {v_prev, pc_prev, in_prev});
    end else if (ifid_valid_o) begin
      check_eq("stream_pc", ifid_pc_o, exp_q[0]);
      check_eq("stream_instr", ifid_instr_o, instr_of(exp_q[0]));
      nxt = exp_q.pop_front() + 9'd4;
      exp_q.push_back(nxt);
      n_entries++;
    end else begin
      check_eq("bubble", {ifid_pc_o, ifid_instr_o}, {pc_prev, NOP});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_ifid", {ifid_valid_o, ifid_pc_o, ifid_instr_o}, {1'b0, 9'd0, NOP});
    check_eq("rst_state", dbg_state, 0);
    do_reset();

    // 1-cycle memory, sustained fetch
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_eq("t1_req", last_req, 1);
      check_eq("t1_addr", last_addr, 9'(4 * k));
      if (k >= 1) check_eq("t1_ifid", {ifid_valid_o, ifid_pc_o}, {1'b1, 9'(4 * (k - 1))});
    end

    // stall for 3 cycles with PC 8 in IF/ID
    do_reset();
    for (int k = 0; k < 4; k++) cycle();
    check_eq("t2_pc8", ifid_pc_o, 9'd8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("t2_noreq", last_req, 0);
      check_eq("t2_keep8", ifid_pc_o, 9'd8);
    end
    stall = 1'b0;
    cycle();
    check_eq("t2_resume", {last_req, last_addr}, {1'b1, 9'd16});
    check_eq("t2_pc12", {ifid_valid_o, ifid_pc_o}, {1'b1, 9'd12});
    cycle();
    check_eq("t2_pc16", {ifid_valid_o, ifid_pc_o}, {1'b1, 9'd16});

    // redirect while 0x20 outstanding on 3-cycle memory
    do_reset();
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cycle();
      if (last_req && last_addr == 9'h20) found = 1'b1;
    end
    check_eq("t3_found20", found, 1);
    redirect = 1'b1; redirect_pc = 9'h40;
    cycle();
    redirect = 1'b0;
    check_eq("t3_req_redir", last_req, 0);
    cycle();
    check_eq("t3_drop1", last_req, 0);
    cycle();
    check_eq("t3_drop2", last_req, 0);
    cycle();
    check_eq("t3_target", {last_req, last_addr}, {1'b1, 9'h40});
    for (int k = 0; k < 2; k++) begin
      cycle();
      check_eq("t3_wait_bubble", {ifid_valid_o, ifid_instr_o}, {1'b0, NOP});
    end
    cycle();
    check_eq("t3_pc40", {ifid_valid_o, ifid_pc_o}, {1'b1, 9'h40});

    // unaligned redirect and PC wrap
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = 9'h1FF;
    cycle();
    redirect = 1'b0;
    check_eq("t4_noreq", last_req, 0);
    cycle();
    check_eq("t4_req1fc", {last_req, last_addr}, {1'b1, 9'h1FC});
    cycle();
    check_eq("t4_wrap", {last_req, last_addr}, {1'b1, 9'h000});
    check_eq("t4_ifid1fc", {ifid_valid_o, ifid_pc_o}, {1'b1, 9'h1FC});
    cycle();
    check_eq("t4_ifid0", {ifid_valid_o, ifid_pc_o}, {1'b1, 9'h000});

    // redirect + stall with hold full
    do_reset();
    repeat (4) cycle();
    stall = 1'b1;
    cycle(); cycle();
    check_eq("t5_holdfull_noreq", last_req, 0);
    redirect = 1'b1; redirect_pc = 9'h80;
    cycle();
    redirect = 1'b0; stall = 1'b0;
    check_eq("t5_bubble", {ifid_valid_o, ifid_instr_o}, {1'b0, NOP});
    cycle();
    check_eq("t5_req80", {last_req, last_addr}, {1'b1, 9'h80});
    check_eq("t5_no_hold_leak", ifid_valid_o, 0);
    cycle();
    check_eq("t5_pc80", {ifid_valid_o, ifid_pc_o}, {1'b1, 9'h80});

    // reset with a request outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (5) cycle();
    check_eq("t6_pending", mem_pend, 1);
    imem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("t6_req", imem_req, 0);
    check_eq("t6_addr", imem_addr, 0);
    check_eq("t6_ifid", {ifid_valid_o, ifid_pc_o, ifid_instr_o}, {1'b0, 9'd0, NOP});
    check_eq("t6_state", dbg_state, 0);
    do_reset();
    cycle();
    check_eq("t6_restart", {last_req, last_addr}, {1'b1, 9'd0});

    // randomized traffic
    do_reset();
    lat_min = 1; lat_max = 4;
    n_entries = 0;
    for (int k = 0; k < 1500; k++) begin
      stall       = ($urandom_range(99, 0) < 25);
      redirect    = ($urandom_range(99, 0) < 6);
      redirect_pc = 9'($urandom());
      cycle();
    end
    stall = 1'b0; redirect = 1'b0;
    check_eq("rand_progress", n_entries > 100, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
